// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and sizing for the memory port arbiter
//
// Contents:
//   arbState_t  : IDLE / WAIT / RESP access sequencer states
//   grant_t     : which requester owns the memory port (GRANT_I / GRANT_D)
//   DEFAULT_TIMEOUT, TIMEOUT_CNT_W : default WAIT bound and its counter width
//   cntWidth()  : counter width for an arbitrary timeout bound

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arbState_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int TIMEOUT_CNT_W   = $clog2(DEFAULT_TIMEOUT);

  // The counter only has to reach timeout-1, so $clog2 is exact; a floor of
  // one bit keeps tiny bounds from producing a zero-width vector.
  function automatic int cntWidth(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - combinational two-requester round-robin pick
//
// Ports:
//   req[1:0]  in  request vector, bit 0 = instruction port, bit 1 = data port
//   lastGrant in  port granted most recently
//   grant     out selected port (meaningful only when valid)
//   valid     out at least one request present

module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     lastGrant,
  output grant_t     grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = GRANT_I;
    unique case (req)
      2'b01:   grant = GRANT_I;
      2'b10:   grant = GRANT_D;
      // Conflict: the port that did not win last time gets the slot.
      2'b11:   grant = (lastGrant == GRANT_D) ? GRANT_I : GRANT_D;
      default: grant = GRANT_I;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one main-memory port between fetch and load/store
//
// Ports:
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   i_req/i_addr                  instruction read request (level) and address
//   i_ready/i_rdata/i_err         instruction response pulse, held data, timeout flag
//   d_req/d_we/d_addr/d_wdata     data request (level), write enable, address, write data
//   d_ready/d_rdata/d_err         data response pulse, held read data, timeout flag
//   mem_addr/mem_wdata            latched address / write data toward memory
//   mem_read/mem_write            strobes, asserted for the whole WAIT state
//   mem_rdata/mem_data_ready      memory read data and completion (sampled in WAIT)
//   mem_data_grabbed              pulse in RESP when a non-timed-out result was consumed

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_ready,
  output logic              mem_data_grabbed
);

  localparam int              CNT_W    = cntWidth(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arbState_t         state;
  arbState_t         nextState;

  grant_t            lastGrant;
  grant_t            curGrant;
  grant_t            pickGrant;
  logic              pickValid;

  logic              opWe;
  logic              errFlag;
  logic [CNT_W-1:0]  timeoutCnt;
  logic [ADDR_W-1:0] memAddrQ;
  logic [DATA_W-1:0] memWdataQ;
  logic [DATA_W-1:0] iRdataQ;
  logic [DATA_W-1:0] dRdataQ;

  logic              grantNow;
  logic              waitDone;
  logic              waitTimeout;

  rr_arbiter_2 uArb (
    .req       ({d_req, i_req}),
    .lastGrant (lastGrant),
    .grant     (pickGrant),
    .valid     (pickValid)
  );

  assign grantNow    = (state == IDLE) && pickValid;
  // A completion arriving on the last allowed WAIT cycle beats the timeout.
  assign waitDone    = (state == WAIT) && mem_data_ready;
  assign waitTimeout = (state == WAIT) && !mem_data_ready && (timeoutCnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    nextState = pickValid ? WAIT : IDLE;
      WAIT:    nextState = (waitDone || waitTimeout) ? RESP : WAIT;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state so a reset clears them at once
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    i_ready          = 1'b0;
    d_ready          = 1'b0;
    i_err            = 1'b0;
    d_err            = 1'b0;
    mem_data_grabbed = 1'b0;
    unique case (state)
      WAIT: begin
        mem_read  = !opWe;
        mem_write = opWe;
      end
      RESP: begin
        i_ready          = (curGrant == GRANT_I);
        d_ready          = (curGrant == GRANT_D);
        i_err            = (curGrant == GRANT_I) && errFlag;
        d_err            = (curGrant == GRANT_D) && errFlag;
        mem_data_grabbed = !errFlag;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant bookkeeping, payload latches, timeout counter and read-data holding
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant  <= GRANT_D;
      curGrant   <= GRANT_I;
      opWe       <= 1'b0;
      errFlag    <= 1'b0;
      timeoutCnt <= '0;
      memAddrQ   <= '0;
      memWdataQ  <= '0;
      iRdataQ    <= '0;
      dRdataQ    <= '0;
    end else begin
      if (grantNow) begin
        lastGrant  <= pickGrant;
        curGrant   <= pickGrant;
        timeoutCnt <= '0;
        errFlag    <= 1'b0;
        if (pickGrant == GRANT_D) begin
          memAddrQ  <= d_addr;
          memWdataQ <= d_wdata;
          opWe      <= d_we;
        end else begin
          // Fetch is read-only; mem_wdata keeps whatever the last write left.
          memAddrQ <= i_addr;
          opWe     <= 1'b0;
        end
      end else if (waitDone) begin
        errFlag <= 1'b0;
        if (!opWe) begin
          if (curGrant == GRANT_I) begin
            iRdataQ <= mem_rdata;
          end else begin
            dRdataQ <= mem_rdata;
          end
        end
      end else if (waitTimeout) begin
        // Read-data registers deliberately untouched: the requester sees the
        // previous value alongside err.
        errFlag <= 1'b1;
      end else if (state == WAIT) begin
        timeoutCnt <= timeoutCnt + CNT_W'(1);
      end
    end
  end

  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign i_rdata   = iRdataQ;
  assign d_rdata   = dRdataQ;

endmodule
